// File: rtl/servo_position_ramp.sv
// Servo position command stage: accepts clamped target positions and slews
// duty_cycle toward them at a fixed step rate, then settles before signalling done.
module servo_position_ramp #(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned STEP_HZ    = 1000,
  parameter int unsigned STEP_SIZE  = 1,
  parameter int unsigned POS_MIN    = 0,
  parameter int unsigned POS_MAX    = 255,
  parameter int unsigned INIT_POS   = 0,
  parameter int unsigned HOLD_TICKS = 20
) (
  input  logic       Main_clock,
  input  logic       reset,
  input  logic [7:0] target_pos,
  input  logic       target_valid,
  output logic       target_ready,
  output logic [7:0] duty_cycle,
  output logic       busy,
  output logic       done
);

  localparam int unsigned DIV    = CLK_FREQ / STEP_HZ;
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned HOLD_W = (HOLD_TICKS > 0) ? $clog2(HOLD_TICKS + 1) : 1;

  localparam logic [7:0] MIN_POS    = 8'(POS_MIN);
  localparam logic [7:0] MAX_POS    = 8'(POS_MAX);
  localparam logic [7:0] INIT_CLAMP = 8'((INIT_POS > POS_MAX) ? POS_MAX :
                                         ((INIT_POS > POS_MIN) ? INIT_POS : POS_MIN));
  localparam logic [7:0] STEP8      = 8'(STEP_SIZE);
  localparam logic [8:0] STEP9      = 9'(STEP_SIZE);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RAMP = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [7:0]        duty_nxt;
  logic [7:0]        tgt, tgt_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic [DIV_W-1:0]  presc, presc_nxt;
  logic              busy_nxt, done_nxt;

  logic       step_tick;
  logic       accept;
  logic [7:0] t_hi, t_clamp;
  logic       move_up;
  logic [8:0] diff;

  assign target_ready = (state != RAMP) & ~reset;
  assign accept       = target_valid & (state != RAMP);
  assign step_tick    = (presc == DIV_LAST);

  // Clamp the requested target into the allowed range
  assign t_hi    = (target_pos < MAX_POS) ? target_pos : MAX_POS;
  assign t_clamp = (t_hi > MIN_POS) ? t_hi : MIN_POS;

  // 9-bit distance to target keeps the final step from overshooting or wrapping
  assign move_up = (tgt > duty_cycle);
  assign diff    = move_up ? ({1'b0, tgt} - {1'b0, duty_cycle})
                           : ({1'b0, duty_cycle} - {1'b0, tgt});

  always_ff @(posedge Main_clock) begin
    if (reset) begin
      state      <= IDLE;
      duty_cycle <= INIT_CLAMP;
      tgt        <= INIT_CLAMP;
      hold_cnt   <= '0;
      presc      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nxt;
      duty_cycle <= duty_nxt;
      tgt        <= tgt_nxt;
      hold_cnt   <= hold_nxt;
      presc      <= presc_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    duty_nxt  = duty_cycle;
    tgt_nxt   = tgt;
    hold_nxt  = hold_cnt;
    done_nxt  = 1'b0;
    presc_nxt = step_tick ? '0 : presc + DIV_W'(1);

    // An accept (IDLE or HOLD) takes priority over stepping or hold countdown
    if (accept) begin
      tgt_nxt = t_clamp;
      if (t_clamp == duty_cycle) begin
        state_nxt = HOLD;
        hold_nxt  = HOLD_LOAD;
      end else begin
        state_nxt = RAMP;
      end
    end else begin
      case (state)
        IDLE: state_nxt = IDLE;
        RAMP: begin
          if (step_tick) begin
            if (diff <= STEP9) begin
              duty_nxt  = tgt;
              state_nxt = HOLD;
              hold_nxt  = HOLD_LOAD;
            end else if (move_up) begin
              duty_nxt = duty_cycle + STEP8;
            end else begin
              duty_nxt = duty_cycle - STEP8;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == '0) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else if (step_tick) begin
            hold_nxt = hold_cnt - HOLD_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_servo_position_ramp.sv
// Bench for servo_position_ramp: three parameterisations driven in lockstep and
// compared every cycle against a behavioural model of the ramp/settle sequence.
module tb_servo_position_ramp;

  localparam int M_IDLE = 0;
  localparam int M_RAMP = 1;
  localparam int M_HOLD = 2;

  logic       clk = 1'b0;
  logic [2:0] rst, tv, rdy, bsy, dn;
  logic [7:0] tp [3];
  logic [7:0] dc [3];

  int p_div[3], p_step[3], p_min[3], p_max[3], p_init[3], p_hold[3];
  int m_pos[3], m_tgt[3], m_ph[3], m_hold[3], m_pre[3], m_done[3];
  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  servo_position_ramp #(.CLK_FREQ(1000), .STEP_HZ(100), .STEP_SIZE(1), .POS_MIN(0),
    .POS_MAX(255), .INIT_POS(25), .HOLD_TICKS(2)) dut_a (
    .Main_clock(clk), .reset(rst[0]), .target_pos(tp[0]), .target_valid(tv[0]),
    .target_ready(rdy[0]), .duty_cycle(dc[0]), .busy(bsy[0]), .done(dn[0]));

  servo_position_ramp #(.CLK_FREQ(900), .STEP_HZ(300), .STEP_SIZE(4), .POS_MIN(0),
    .POS_MAX(255), .INIT_POS(30), .HOLD_TICKS(0)) dut_b (
    .Main_clock(clk), .reset(rst[1]), .target_pos(tp[1]), .target_valid(tv[1]),
    .target_ready(rdy[1]), .duty_cycle(dc[1]), .busy(bsy[1]), .done(dn[1]));

  servo_position_ramp #(.CLK_FREQ(500), .STEP_HZ(500), .STEP_SIZE(3), .POS_MIN(10),
    .POS_MAX(125), .INIT_POS(0), .HOLD_TICKS(1)) dut_c (
    .Main_clock(clk), .reset(rst[2]), .target_pos(tp[2]), .target_valid(tv[2]),
    .target_ready(rdy[2]), .duty_cycle(dc[2]), .busy(bsy[2]), .done(dn[2]));

  function automatic int clampv(int i, int v);
    if (v < p_min[i]) return p_min[i];
    if (v > p_max[i]) return p_max[i];
    return v;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Behavioural model: one clock edge of servo i, using the inputs currently applied
  function automatic void model_edge(int i);
    int  d;
    bit  tick;
    if (rst[i]) begin
      m_pos[i] = clampv(i, p_init[i]);
      m_tgt[i] = m_pos[i];
      m_ph[i] = M_IDLE; m_hold[i] = 0; m_pre[i] = 0; m_done[i] = 0;
      return;
    end
    tick = (m_pre[i] == p_div[i] - 1);
    m_pre[i] = tick ? 0 : m_pre[i] + 1;
    m_done[i] = 0;
    if (tv[i] && m_ph[i] != M_RAMP) begin
      m_tgt[i] = clampv(i, int'(tp[i]));
      if (m_tgt[i] == m_pos[i]) begin
        m_ph[i] = M_HOLD; m_hold[i] = p_hold[i];
      end else begin
        m_ph[i] = M_RAMP;
      end
    end else if (m_ph[i] == M_RAMP) begin
      if (tick) begin
        d = m_tgt[i] - m_pos[i];
        if (d <= p_step[i] && -d <= p_step[i]) begin
          m_pos[i] = m_tgt[i]; m_ph[i] = M_HOLD; m_hold[i] = p_hold[i];
        end else begin
          m_pos[i] = (d > 0) ? m_pos[i] + p_step[i] : m_pos[i] - p_step[i];
        end
      end
    end else if (m_ph[i] == M_HOLD) begin
      if (m_hold[i] == 0) begin
        m_ph[i] = M_IDLE; m_done[i] = 1;
      end else if (tick) begin
        m_hold[i] = m_hold[i] - 1;
      end
    end
  endfunction

  // One clock cycle: check ready before the edge, outputs on the following negedge
  task automatic step();
    #1;
    for (int i = 0; i < 3; i++)
      chk($sformatf("ready%0d", i), int'(rdy[i]), (m_ph[i] != M_RAMP && !rst[i]) ? 1 : 0);
    for (int i = 0; i < 3; i++) model_edge(i);
    @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("duty%0d", i), int'(dc[i]), m_pos[i]);
      chk($sformatf("busy%0d", i), int'(bsy[i]), (m_ph[i] != M_IDLE) ? 1 : 0);
      chk($sformatf("done%0d", i), int'(dn[i]), m_done[i]);
    end
  endtask

  task automatic wait_for(int i, int ph, int pos, int limit, string tag);
    int k = 0;
    while (!(m_ph[i] == ph && (pos < 0 || m_pos[i] == pos)) && k < limit) begin
      step();
      k++;
    end
    if (!(m_ph[i] == ph && (pos < 0 || m_pos[i] == pos))) begin
      n_vec++;
      n_err++;
      $error("FAIL %s timeout observed_state=%0d expected_state=%0d", tag, m_ph[i], ph);
    end
  endtask

  task automatic accept(int i, int v);
    tv[i] = 1'b1;
    tp[i] = 8'(v);
    step();
    tv[i] = 1'b0;
  endtask

  initial begin
    p_div  = '{10, 3, 1};
    p_step = '{1, 4, 3};
    p_min  = '{0, 0, 10};
    p_max  = '{255, 255, 125};
    p_init = '{25, 30, 0};
    p_hold = '{2, 0, 1};
    for (int i = 0; i < 3; i++) begin
      m_pos[i] = 0; m_tgt[i] = 0; m_ph[i] = M_IDLE;
      m_hold[i] = 0; m_pre[i] = 0; m_done[i] = 0;
      tp[i] = 8'd0;
    end
    rst = 3'b111;
    tv  = 3'b000;

    repeat (3) step();
    rst = 3'b000;
    chk("a_init_duty", int'(dc[0]), 25);
    chk("b_init_duty", int'(dc[1]), 30);
    chk("c_init_clamped", int'(dc[2]), 10);

    // Ramp 25 -> 30 one step per 10 cycles, settle, done
    accept(0, 30);
    chk("a_busy_after_accept", int'(bsy[0]), 1);
    wait_for(0, M_IDLE, -1, 200, "a_ramp30");
    chk("a_final30", int'(dc[0]), 30);

    // Targets offered during RAMP are ignored
    accept(0, 60);
    tv[0] = 1'b1;
    tp[0] = 8'd50;
    repeat (15) step();
    tv[0] = 1'b0;
    wait_for(0, M_HOLD, 60, 400, "a_reach60");
    chk("a_ignored50", int'(dc[0]), 60);

    // Accept in HOLD on a step_tick cycle wins, no done for the abandoned hold
    while (!(m_ph[0] == M_HOLD && m_pre[0] == p_div[0] - 1) && m_ph[0] == M_HOLD) step();
    chk("a_hold_on_tick", m_ph[0], M_HOLD);
    accept(0, 40);
    chk("a_retarget_busy", int'(bsy[0]), 1);
    chk("a_retarget_no_done", int'(dn[0]), 0);
    chk("a_retarget_duty", int'(dc[0]), 60);

    // Reset in the middle of a ramp
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    accept(0, 30);
    wait_for(0, M_RAMP, 28, 200, "a_reach28");
    rst[0] = 1'b1;
    step();
    rst[0] = 1'b0;
    chk("a_midreset_duty", int'(dc[0]), 25);
    chk("a_midreset_busy", int'(bsy[0]), 0);
    chk("a_midreset_done", int'(dn[0]), 0);

    // Step 4: shortened final step, and no wrap at the top
    accept(1, 21);
    wait_for(1, M_IDLE, -1, 100, "b_ramp21");
    chk("b_final21", int'(dc[1]), 21);
    accept(1, 250);
    wait_for(1, M_IDLE, -1, 1000, "b_ramp250");
    chk("b_final250", int'(dc[1]), 250);
    accept(1, 255);
    wait_for(1, M_IDLE, -1, 100, "b_ramp255");
    chk("b_final255", int'(dc[1]), 255);

    // Clamping to [10,125] and equal-target straight to HOLD
    accept(2, 200);
    wait_for(2, M_IDLE, -1, 500, "c_ramp200");
    chk("c_clamp_hi", int'(dc[2]), 125);
    accept(2, 3);
    wait_for(2, M_IDLE, -1, 500, "c_ramp3");
    chk("c_clamp_lo", int'(dc[2]), 10);
    accept(2, 10);
    chk("c_equal_hold", m_ph[2], M_HOLD);
    chk("c_equal_busy", int'(bsy[2]), 1);
    chk("c_equal_duty", int'(dc[2]), 10);
    wait_for(2, M_IDLE, -1, 20, "c_equal_idle");

    // Randomised traffic with occasional resets
    repeat (4000) begin
      for (int i = 0; i < 3; i++) begin
        rst[i] = ($urandom_range(0, 299) == 0);
        tv[i]  = ($urandom_range(0, 5) == 0);
        tp[i]  = 8'($urandom_range(0, 255));
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
